// File: rtl/dbg_frame_tx.sv
// rtl/dbg_frame_tx.sv - snapshot debug words and stream them as a framed UART 8N1 packet

module dbg_frame_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          NUM_WORDS    = 3,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trig_i,
    input  logic [NUM_WORDS*32-1:0] dbg_words_i,
    output logic                    tx_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             frame_cnt_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int NUM_BYTES = 4 * NUM_WORDS + 2;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W    = $clog2(NUM_BYTES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [NUM_WORDS*32-1:0] snap_q, snap_d;
    logic                    tx_q, tx_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic                    done;
    logic                    baud_end;
    logic [7:0]              csum;
    logic [7:0]              tx_byte;

    always_comb begin
        csum = 8'h00;
        for (int k = 0; k < 4 * NUM_WORDS; k++) begin
            csum = csum ^ snap_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        snap_d      = snap_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        done        = 1'b0;
        baud_end    = (baud_q == BAUD_LAST);

        // Any request outside IDLE is lost, including the final STOP cycle.
        if (trig_i && state_q != IDLE) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (trig_i) begin
                    snap_d  = dbg_words_i;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        byte_d      = '0;
                        state_d     = IDLE;
                        done        = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte index 0 is the sync byte, then payload bytes, then the checksum.
    always_comb begin
        tx_byte = SYNC_BYTE;
        if (byte_d == BYTE_LAST) begin
            tx_byte = csum;
        end
        for (int k = 0; k < 4 * NUM_WORDS; k++) begin
            if (byte_d == BYTE_W'(k + 1)) begin
                tx_byte = snap_q[8*k +: 8];
            end
        end
    end

    // The line is registered from the next-state values so it changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_byte[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            snap_q      <= '0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            snap_q      <= snap_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done;
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb/tb_dbg_frame_tx.sv - self-checking bench for dbg_frame_tx

module tb_dbg_frame_tx;

    localparam int CPB       = 4;
    localparam int NW        = 3;
    localparam int FRAME_CYC = (4 * NW + 2) * 10 * CPB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trig_i = 1'b0;
    logic [NW*32-1:0] dbg_words_i = '0;
    logic             tx_o;
    logic             busy_o;
    logic             done_o;
    logic [15:0]      frame_cnt_o;
    logic [15:0]      drop_cnt_o;

    dbg_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .NUM_WORDS    (NW),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trig_i),
        .dbg_words_i (dbg_words_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .frame_cnt_o (frame_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  csum;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cycles = 0;
    int          done_pulses = 0;
    logic [15:0] exp_frames = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy_o) busy_cycles++;
        if (done_o) done_pulses++;
    end

    // Reference 8N1 receiver sampling at cycle 2 of each 4-cycle bit.
    int         rx_cnt = 0;
    bit         rx_active = 1'b0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx_o === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 1;
            end
        end else begin
            if (rx_cnt == 2) begin
                check("rx_start_bit", tx_o, 1'b0);
            end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) begin
                rx_byte[(rx_cnt - 6) / 4] = tx_o;
            end else if (rx_cnt == 38) begin
                check("rx_stop_bit", tx_o, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_byte: got %0h expected none", rx_byte);
                end else begin
                    check("rx_byte", rx_byte, exp_q.pop_front());
                end
            end
            if (rx_cnt == 39) rx_active = 1'b0;
            rx_cnt++;
        end
    end

    task automatic push_frame(input logic [NW*32-1:0] w, input logic [7:0] csum);
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 4 * NW; k++) exp_q.push_back(w[8*k +: 8]);
        exp_q.push_back(csum);
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic send_frame(input vec_t v, input bit corrupt);
        logic [NW*32-1:0] w;
        int b0, d0;
        w = {v.w2, v.w1, v.w0};
        @(posedge clk); #1;
        dbg_words_i = w;
        trig_i      = 1'b1;
        push_frame(w, v.csum);
        b0 = busy_cycles;
        d0 = done_pulses;
        @(posedge clk); #1;
        trig_i = 1'b0;
        if (corrupt) dbg_words_i = '1;
        @(negedge clk);
        check("latency_tx_low", tx_o, 1'b0);
        check("latency_busy", busy_o, 1'b1);
        wait_done("frame_done_seen");
        repeat (3) @(negedge clk);
        exp_frames = exp_frames + 16'd1;
        check("busy_cycles", busy_cycles - b0, FRAME_CYC);
        check("done_pulses", done_pulses - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("frame_cnt", frame_cnt_o, exp_frames);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] drop0;
        int          d0;

        vecs[0] = '{32'd12,         32'h000000A5, 32'h00F5DA83, 8'h05};
        vecs[1] = '{32'h0,          32'h0,        32'h0,        8'h00};
        vecs[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00};
        vecs[3] = '{32'h01020304,   32'h10203040, 32'h0,        8'h44};
        vecs[4] = '{32'hDEADBEEF,   32'h0,        32'h0,        8'h22};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_frame_cnt", frame_cnt_o, 16'h0);
        check("rst_drop_cnt", drop_cnt_o, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) send_frame(vecs[i], 1'b0);
        check("no_drops_single", drop_cnt_o, 16'h0);

        // Input changes right after the snapshot edge must not leak into the frame.
        send_frame(vecs[0], 1'b1);
        dbg_words_i = {vecs[0].w2, vecs[0].w1, vecs[0].w0};

        // Trigger held for 600 cycles: one frame, one idle cycle, a second frame.
        drop0 = drop_cnt_o;
        push_frame(dbg_words_i, vecs[0].csum);
        push_frame(dbg_words_i, vecs[0].csum);
        @(posedge clk); #1;
        trig_i = 1'b1;
        fork
            begin
                repeat (600) @(posedge clk);
                #1 trig_i = 1'b0;
            end
            begin
                wait_done("held_done1_seen");
                @(negedge clk);
                check("held_drop_first", 16'(drop_cnt_o - drop0), 16'd560);
                check("held_gap_idle", busy_o, 1'b0);
                @(negedge clk);
                check("held_restart", busy_o, 1'b1);
                wait_done("held_done2_seen");
                repeat (3) @(negedge clk);
                check("held_drop_total", 16'(drop_cnt_o - drop0), 16'd598);
            end
        join
        exp_frames = exp_frames + 16'd2;
        check("held_frame_cnt", frame_cnt_o, exp_frames);
        check("held_queue_drained", exp_q.size(), 0);

        // Reset in cycle 200 of a frame.
        push_frame(dbg_words_i, vecs[0].csum);
        d0 = done_pulses;
        @(posedge clk); #1;
        trig_i = 1'b1;
        @(posedge clk); #1;
        trig_i = 1'b0;
        repeat (198) @(posedge clk);
        #2;
        check("pre_rst_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_frame_cnt", frame_cnt_o, 16'h0);
        check("abort_drop_cnt", drop_cnt_o, 16'h0);
        exp_q.delete();
        exp_frames = '0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_pulses - d0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(vecs[3], 1'b0);

        // Frame counter wrap via a preloaded count.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        check("preload_frame_cnt", frame_cnt_o, 16'hFFFF);
        exp_frames = 16'hFFFF;
        send_frame(vecs[4], 1'b0);
        check("wrap_frame_cnt", frame_cnt_o, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
